// File: rtl/conv_seq_ctrl.sv
// Sequencer for a line-buffered convolution engine: it loads the weights, scans the
// padded IFM plane, walks the input channels and output filters, and flags complete windows.
module conv_seq_ctrl #(
  parameter int KMAX    = 7,
  parameter int IFM_MAX = 64,
  parameter int PAD_MAX = 3,
  parameter int CH_MAX  = 512,
  localparam int KW = $clog2(KMAX + 1),
  localparam int SW = $clog2(IFM_MAX + 2 * PAD_MAX + 1),
  localparam int AW = $clog2(IFM_MAX),
  localparam int CW = $clog2(CH_MAX + 1)
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   start_conv,
  input  logic                   abort,
  input  logic                   in_valid,
  input  logic [KW-1:0]          cfg_k,
  input  logic [SW-1:0]          cfg_ifm,
  input  logic [1:0]             cfg_pad,
  input  logic [1:0]             cfg_stride,
  input  logic [CW-1:0]          cfg_ci,
  input  logic [CW-1:0]          cfg_co,
  input  logic                   cfg_pool,
  output logic                   ifm_read,
  output logic                   wgt_read,
  output logic [KMAX*KMAX-1:0]   set_wgt,
  output logic                   rd_clr,
  output logic                   win_valid,
  output logic                   acc_clr,
  output logic                   out_valid,
  output logic [AW-1:0]          addr_x,
  output logic [AW-1:0]          addr_y,
  output logic [CW-1:0]          ch_idx,
  output logic [CW-1:0]          flt_idx,
  output logic                   busy,
  output logic                   end_conv,
  output logic                   cfg_err
);

  localparam int NW  = KMAX * KMAX;
  localparam int WCW = $clog2(NW + 1);

  typedef enum logic [2:0] {IDLE, LOAD_WGT, COMPUTE, ROW_END, CH_END, FLT_END, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k_r;
  logic [SW-1:0]   ifm_r;
  logic [1:0]      pad_r;
  logic [1:0]      stride_r;
  logic [CW-1:0]   ci_r;
  logic [CW-1:0]   co_r;
  logic            pool_r;
  logic [SW-1:0]   x;
  logic [SW-1:0]   y;
  logic [1:0]      xph;
  logic [1:0]      yph;
  logic [CW-1:0]   ch;
  logic [CW-1:0]   flt;
  logic [WCW-1:0]  wcnt;

  logic            cfg_bad;
  logic [SW-1:0]   p_last;
  logic [SW-1:0]   k_last;
  logic [WCW-1:0]  k_ext;
  logic [WCW-1:0]  kk_last;
  logic [SW-1:0]   x_inc;
  logic [SW-1:0]   y_inc;
  logic [1:0]      stride_last;
  logic [1:0]      x_ph_next;
  logic [1:0]      y_ph_next;
  logic            in_x;
  logic            in_y;
  logic            advance;
  logic            win_pos;

  assign cfg_bad = (int'(cfg_k) == 0) || (int'(cfg_k) > KMAX) || (int'(cfg_stride) == 0) ||
                   (int'(cfg_pad) > PAD_MAX) || (int'(cfg_ifm) > IFM_MAX) ||
                   (int'(cfg_ci) == 0) || (int'(cfg_co) == 0) ||
                   (int'(cfg_ifm) + 2 * int'(cfg_pad) < int'(cfg_k));

  assign p_last      = ifm_r + SW'({pad_r, 1'b0}) - SW'(1);
  assign k_last      = SW'(k_r) - SW'(1);
  assign k_ext       = WCW'(k_r);
  assign kk_last     = k_ext * k_ext - WCW'(1);
  assign x_inc       = x + SW'(1);
  assign y_inc       = y + SW'(1);
  assign stride_last = stride_r - 2'd1;

  // Stride phase of a coordinate stepping forward; it restarts at 0 on the first window column/row.
  assign x_ph_next = (x_inc <= k_last) ? 2'd0 : ((xph == stride_last) ? 2'd0 : xph + 2'd1);
  assign y_ph_next = (y_inc <= k_last) ? 2'd0 : ((yph == stride_last) ? 2'd0 : yph + 2'd1);

  assign in_x    = (x >= SW'(pad_r)) && (x < SW'(pad_r) + ifm_r);
  assign in_y    = (y >= SW'(pad_r)) && (y < SW'(pad_r) + ifm_r);
  assign win_pos = (x >= k_last) && (y >= k_last) && (xph == 2'd0) && (yph == 2'd0);

  assign ifm_read  = (state == COMPUTE) && in_x && in_y;
  assign advance   = !ifm_read || in_valid;
  assign win_valid = (state == COMPUTE) && advance && win_pos;
  assign acc_clr   = win_valid && (ch == '0);
  assign wgt_read  = (state == LOAD_WGT);
  assign set_wgt   = (state == LOAD_WGT) ? (NW'(1) << wcnt) : '0;
  assign rd_clr    = (state == ROW_END) || (state == CH_END) || (state == FLT_END);
  assign addr_x    = ifm_read ? AW'(x - SW'(pad_r)) : '0;
  assign addr_y    = ifm_read ? AW'(y - SW'(pad_r)) : '0;
  assign ch_idx    = ch;
  assign flt_idx   = flt;
  assign busy      = (state != IDLE);
  assign end_conv  = (state == DONE);

  // Abort outranks every transition, including the one into DONE.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_r       <= '0;
      ifm_r     <= '0;
      pad_r     <= '0;
      stride_r  <= '0;
      ci_r      <= '0;
      co_r      <= '0;
      pool_r    <= 1'b0;
      x         <= '0;
      y         <= '0;
      xph       <= '0;
      yph       <= '0;
      ch        <= '0;
      flt       <= '0;
      wcnt      <= '0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err   <= 1'b0;
      out_valid <= !abort && win_valid && (pool_r || (ch == ci_r - CW'(1)));
      if (abort) begin
        state <= IDLE;
        x     <= '0;
        y     <= '0;
        xph   <= '0;
        yph   <= '0;
        ch    <= '0;
        flt   <= '0;
        wcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_conv) begin
              if (cfg_bad) begin
                cfg_err <= 1'b1;
              end else begin
                k_r      <= cfg_k;
                ifm_r    <= cfg_ifm;
                pad_r    <= cfg_pad;
                stride_r <= cfg_stride;
                ci_r     <= cfg_ci;
                co_r     <= cfg_co;
                pool_r   <= cfg_pool;
                x        <= '0;
                y        <= '0;
                xph      <= '0;
                yph      <= '0;
                ch       <= '0;
                flt      <= '0;
                wcnt     <= '0;
                state    <= LOAD_WGT;
              end
            end
          end
          LOAD_WGT: begin
            if (wcnt == kk_last) begin
              wcnt  <= '0;
              state <= COMPUTE;
            end else begin
              wcnt <= wcnt + WCW'(1);
            end
          end
          COMPUTE: begin
            if (advance) begin
              if (x != p_last) begin
                x   <= x_inc;
                xph <= x_ph_next;
              end else if (y != p_last) begin
                x     <= '0;
                xph   <= '0;
                y     <= y_inc;
                yph   <= y_ph_next;
                state <= ROW_END;
              end else if (ch != ci_r - CW'(1)) begin
                x     <= '0;
                xph   <= '0;
                y     <= '0;
                yph   <= '0;
                ch    <= ch + CW'(1);
                state <= CH_END;
              end else if (flt != co_r - CW'(1)) begin
                x     <= '0;
                xph   <= '0;
                y     <= '0;
                yph   <= '0;
                ch    <= '0;
                flt   <= flt + CW'(1);
                state <= FLT_END;
              end else begin
                state <= DONE;
              end
            end
          end
          ROW_END: state <= COMPUTE;
          CH_END, FLT_END: state <= LOAD_WGT;
          DONE: begin
            x     <= '0;
            y     <= '0;
            xph   <= '0;
            yph   <= '0;
            ch    <= '0;
            flt   <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- KMAX, 7, largest kernel side.
- IFM_MAX, 64, largest IFM side.
- PAD_MAX, 3, largest padding.
- CH_MAX, 512, largest CI or CO.
REQ-002 Derived widths: KW=clog2(KMAX+1), SW=clog2(IFM_MAX+2*PAD_MAX+1), AW=clog2(IFM_MAX), CW=clog2(CH_MAX+1).
REQ-003 One clock. Reset is asynchronous and active-high.
REQ-004 Ports (name, direction, width, meaning), one per line:
- clk1  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start_conv  in  1  start request, sampled only in IDLE.
- abort  in  1  synchronous abort.
- in_valid  in  1  IFM pixel present this cycle.
- cfg_k  in  KW  kernel side.
- cfg_ifm  in  SW  IFM side.
- cfg_pad  in  2  padding.
- cfg_stride  in  2  stride.
- cfg_ci  in  CW  input channels.
- cfg_co  in  CW  output filters.
- cfg_pool  in  1  pooling/bypass mode.
- ifm_read  out  1  pixel request; consumed when ifm_read and in_valid are both high.
- wgt_read  out  1  weight fetch strobe.
- set_wgt  out  KMAX*KMAX  one-hot weight register select.
- rd_clr  out  1  line-buffer read pointer clear.
- win_valid  out  1  output window complete.
- acc_clr  out  1  accumulator load instead of add.
- out_valid  out  1  final result valid.
- addr_x  out  AW  IFM column.
- addr_y  out  AW  IFM row.
- ch_idx  out  CW  current input channel.
- flt_idx  out  CW  current output filter.
- busy  out  1  not IDLE.
- end_conv  out  1  completion pulse.
- cfg_err  out  1  configuration rejected.

Function
REQ-005 Config latching: all cfg_* inputs are captured when start_conv=1 in IDLE and held until return to IDLE; later cfg_* changes have no effect.
REQ-006 Config error: cfg_k=0, cfg_k>KMAX, cfg_stride=0, cfg_pad>PAD_MAX, cfg_ifm>IFM_MAX, cfg_ci=0, cfg_co=0, or P<k (P=ifm+2*pad) -> cfg_err high for exactly 1 cycle and the block stays IDLE.
REQ-007 FSM states: IDLE, LOAD_WGT, COMPUTE, ROW_END, CH_END, FLT_END, DONE.
REQ-008 Transitions, in priority order:
- abort -> IDLE next cycle, from any state.
- IDLE + valid start -> LOAD_WGT.
- LOAD_WGT after k*k cycles -> COMPUTE.
- COMPUTE, on an advancing cycle at x=P-1:
  - y<P-1 -> ROW_END.
  - else ch<ci-1 -> CH_END.
  - else flt<co-1 -> FLT_END.
  - else -> DONE.
- ROW_END -> COMPUTE.
- CH_END and FLT_END -> LOAD_WGT.
- DONE -> IDLE.
REQ-009 LOAD_WGT: wgt_read=1 each cycle; set_wgt=1<<n for n=0..k*k-1; set_wgt=0 in all other states.
REQ-010 COMPUTE scan: x (column) and y (row) span 0..P-1 over the padded plane.
- ifm_read=1 iff pad<=x<pad+ifm and pad<=y<pad+ifm.
- addr_x=x-pad and addr_y=y-pad when ifm_read=1; both are 0 otherwise.
REQ-011 Advance rule: a COMPUTE cycle advances iff ifm_read=0 or in_valid=1. A non-advancing (stall) cycle holds x, y and all outputs.
REQ-012 ROW_END: x<=0, y<=y+1, rd_clr=1 for 1 cycle.
REQ-013 CH_END: x,y<=0, ch<=ch+1, rd_clr=1.
REQ-014 FLT_END: x,y,ch<=0, flt<=flt+1, rd_clr=1.
REQ-015 win_valid=1 on an advancing COMPUTE cycle iff x>=k-1, y>=k-1, (x-k+1)%stride=0 and (y-k+1)%stride=0.
- Output side O=floor((P-k)/stride)+1.
- Stride residue is tracked with phase counters, not dividers.
REQ-016 acc_clr=win_valid and ch=0.
REQ-017 out_valid is registered, 1 cycle after the source win_valid:
- cfg_pool=0: follows win_valid with ch=ci-1.
- cfg_pool=1: follows every win_valid.
REQ-018 end_conv=1 only in DONE, 1 cycle. busy=1 in every state except IDLE.
REQ-019 A start_conv asserted while busy is ignored.
REQ-020 abort asserted in the same cycle as a DONE entry: abort wins, and end_conv is not asserted.

Reset
REQ-021 While rst=1:
- state=IDLE.
- x, y, ch, flt, latched config = 0.
- All outputs 0, including set_wgt, addr_x/addr_y and ch_idx/flt_idx.
REQ-022 rst asserted mid-operation discards the job. After release the block waits in IDLE for a new start_conv.

Verification
REQ-023 Baseline: k=3, ifm=5, pad=1, stride=1, ci=1, co=1, in_valid=1.
- 9 wgt_read cycles; 25 ifm_read; 25 win_valid; 25 out_valid; 6 rd_clr.
- end_conv exactly 65 cycles after start is sampled.
REQ-024 Multi-channel: same setup with ci=3, co=2.
- 6 LOAD_WGT phases; 150 win_valid; 50 acc_clr; 50 out_valid.
- ch_idx and flt_idx walk 0..2 and 0..1.
REQ-025 Stride/pool: k=4, ifm=9, pad=2, stride=2, ci=2, co=1.
- cfg_pool=0: 50 win_valid, 25 out_valid.
- cfg_pool=1: 50 out_valid.
REQ-026 Stall: in_valid=0 for 4 cycles at the first ifm_read of the baseline.
- addr_x and addr_y hold at 0,0 during the stall.
- end_conv at cycle 69.
REQ-027 Abort/error:
- abort mid-COMPUTE -> IDLE next cycle, busy=0, no end_conv.
- start with cfg_k=0 -> cfg_err 1 cycle, busy stays 0.
- rst pulse mid-LOAD_WGT -> all outputs 0.
